// File: rtl/dct_comp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_stream_if
// Brief    : AXI4-Stream bundle (tdata/tvalid/tready/tlast/tuser).
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_stream_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/dct_comp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dct_comp_arbiter
// Brief    : Round-robin, block-granular (8 rows) arbiter of N_COMP row streams
//            onto one registered AXI4-Stream output feeding a shared DCT.
// Revision : 1.0 - initial release
// ============================================================================
module dct_comp_arbiter #(
    parameter int PX_WIDTH = 8,
    parameter int N_COMP   = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  par_video_i [N_COMP-1:0],
    axi4_stream_if.master par_video_o,
    output logic [1:0]    comp_id_o
);
    localparam int DATA_W = PX_WIDTH * 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  last_gnt_q, last_gnt_d;
    logic [2:0]  row_cnt_q, row_cnt_d;

    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              out_user_q;
    logic [1:0]        comp_id_q;

    logic [DATA_W-1:0] w_tdata [4];
    logic [3:0]        w_tvalid;
    logic [3:0]        w_tlast;
    logic [3:0]        w_tuser;
    logic              w_out_free;
    logic              w_accept;
    logic              w_found;
    logic [1:0]        w_win;
    logic [2:0]        w_cand;

    assign w_out_free = !out_valid_q || par_video_o.tready;
    assign w_accept   = (state_q == BUSY) && w_tvalid[gnt_q] && w_out_free;

    // Slots above N_COMP are tied off so the grant mux always sees 4 inputs.
    for (genvar k = 0; k < 4; k++) begin : g_port
        if (k < N_COMP) begin : g_used
            assign w_tdata[k]  = par_video_i[k].tdata;
            assign w_tvalid[k] = par_video_i[k].tvalid;
            assign w_tlast[k]  = par_video_i[k].tlast;
            assign w_tuser[k]  = par_video_i[k].tuser;
            assign par_video_i[k].tready = (state_q == BUSY) && (gnt_q == 2'(k)) && w_out_free;
        end else begin : g_pad
            assign w_tdata[k]  = '0;
            assign w_tvalid[k] = 1'b0;
            assign w_tlast[k]  = 1'b0;
            assign w_tuser[k]  = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        row_cnt_d  = row_cnt_q;
        w_found    = 1'b0;
        w_win      = gnt_q;
        w_cand     = '0;
        case (state_q)
            IDLE: begin
                // Search starts just after the previous winner.
                for (int i = 1; i <= N_COMP; i++) begin
                    w_cand = 3'(last_gnt_q) + 3'(i);
                    if (w_cand >= 3'(N_COMP)) begin
                        w_cand = w_cand - 3'(N_COMP);
                    end
                    if (!w_found && w_tvalid[w_cand[1:0]]) begin
                        w_found = 1'b1;
                        w_win   = w_cand[1:0];
                    end
                end
                if (w_found) begin
                    gnt_d     = w_win;
                    row_cnt_d = 3'd0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (w_accept) begin
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == 3'd7) begin
                        last_gnt_d = gnt_q;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= 2'd0;
            last_gnt_q <= 2'(N_COMP - 1);
            row_cnt_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            comp_id_q   <= 2'd0;
        end else if (w_accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= w_tdata[gnt_q];
            out_last_q  <= w_tlast[gnt_q];
            out_user_q  <= w_tuser[gnt_q];
            comp_id_q   <= gnt_q;
        end else if (par_video_o.tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign par_video_o.tvalid = out_valid_q;
    assign par_video_o.tdata  = out_data_q;
    assign par_video_o.tlast  = out_last_q;
    assign par_video_o.tuser  = out_user_q;
    assign comp_id_o          = comp_id_q;
endmodule
`default_nettype wire

// File: tb/tb_dct_comp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct_comp_arbiter
// Brief    : Directed, table-driven bench for dct_comp_arbiter (3 components).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct_comp_arbiter;
    localparam int N  = 3;
    localparam int DW = 64;

    logic       clk;
    logic       rst;
    logic [1:0] comp_id;
    logic [2:0] mask;
    logic [2:0] tv;
    logic [2:0] rdy;
    logic       phase;
    logic       out_rdy;
    int         mode;
    int         sent [N];
    logic [2:0] hs_in;
    int         cyc;
    int         total;
    int         bad;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] d;
        logic          u;
        logic          l;
        int            cyc;
    } beat_t;
    beat_t q [$];

    typedef struct {
        logic [2:0]      mask;
        int              mode;
        int              blocks;
        logic [5:0][1:0] order;
    } vec_t;
    vec_t vecs [5];

    axi4_stream_if #(.DATA_W(DW)) in_if [N-1:0] ();
    axi4_stream_if #(.DATA_W(DW)) out_if ();

    dct_comp_arbiter #(.PX_WIDTH(8), .N_COMP(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .par_video_i (in_if),
        .par_video_o (out_if),
        .comp_id_o   (comp_id)
    );

    function automatic logic [DW-1:0] exp_data(input int k, input int n);
        return {8'(k + 1), 8'hA5, 16'(n), 16'(n * 3 + k * 1000), 16'(~n)};
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_src
        assign tv[k]              = mask[k] && phase;
        assign in_if[k].tvalid    = tv[k];
        assign in_if[k].tdata     = exp_data(k, sent[k]);
        assign in_if[k].tuser     = (sent[k] % 8) == 0;
        assign in_if[k].tlast     = (sent[k] % 8) == 7;
        assign rdy[k]             = in_if[k].tready;
    end
    assign out_if.tready = out_rdy;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output stimulus: full-rate tready, or random tready with toggling valid.
    initial begin
        out_rdy = 1'b1;
        phase   = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 1) begin
                out_rdy = 1'($urandom_range(0, 1));
                phase   = ~phase;
            end else begin
                out_rdy = 1'b1;
                phase   = 1'b1;
            end
        end
    end

    logic          stall_prev;
    logic [DW-1:0] hold_d;
    logic [4:0]    hold_c;

    always @(negedge clk) begin
        hs_in = tv & rdy;
        if (!rst && out_if.tvalid && out_rdy) begin
            q.push_back('{id: comp_id, d: out_if.tdata, u: out_if.tuser, l: out_if.tlast, cyc: cyc});
        end
        if (!rst && stall_prev) begin
            check("hold_data", out_if.tdata, hold_d);
            check("hold_ctl", 64'({out_if.tvalid, comp_id, out_if.tuser, out_if.tlast}), 64'(hold_c));
        end
        if (!rst && out_if.tvalid && !out_rdy) begin
            check("stall_tready", 64'(rdy), 64'(0));
        end
        stall_prev = !rst && out_if.tvalid && !out_rdy;
        hold_d     = out_if.tdata;
        hold_c     = {out_if.tvalid, comp_id, out_if.tuser, out_if.tlast};
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (hs_in[k]) sent[k]++;
        end
        hs_in = '0;
    end

    task automatic clear_sources();
        q.delete();
        for (int k = 0; k < N; k++) sent[k] = 0;
        hs_in = '0;
    endtask

    task automatic do_reset();
        mask = 3'b000;
        mode = 0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        clear_sources();
        rst = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string nm);
        for (int i = 0; i < 2000 && q.size() < n; i++) @(negedge clk);
        total++;
        if (q.size() < n) begin
            bad++;
            $display("FAIL %s_timeout: got %0d beats want %0d", nm, q.size(), n);
        end
    endtask

    initial begin
        int   nb;
        int   exp_cnt [N];
        int   c;
        total      = 0;
        bad        = 0;
        cyc        = 0;
        mode       = 0;
        mask       = 3'b000;
        stall_prev = 1'b0;
        hs_in      = '0;
        rst        = 1'b1;
        for (int k = 0; k < N; k++) sent[k] = 0;

        //            mask    mode blk  order {e5..e0}
        vecs[0] = '{3'b101, 0, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0}};
        vecs[1] = '{3'b111, 0, 6, {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0}};
        vecs[2] = '{3'b100, 0, 3, {2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2}};
        vecs[3] = '{3'b010, 1, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1}};
        vecs[4] = '{3'b110, 0, 4, {2'd0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1}};

        // Reset state with no requesters.
        do_reset();
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(out_if.tvalid), 64'(0));
        check("rst_comp_id", 64'(comp_id), 64'(0));
        check("rst_tdata", out_if.tdata, 64'(0));
        check("rst_tuser_tlast", 64'({out_if.tuser, out_if.tlast}), 64'(0));
        check("idle_tready", 64'(rdy), 64'(0));

        foreach (vecs[v]) begin
            do_reset();
            mode = vecs[v].mode;
            mask = vecs[v].mask;
            nb   = vecs[v].blocks * 8;
            wait_beats(nb, $sformatf("vec%0d", v));
            for (int k = 0; k < N; k++) exp_cnt[k] = 0;
            for (int b = 0; b < nb && b < q.size(); b++) begin
                c = int'(vecs[v].order[b / 8]);
                check($sformatf("vec%0d_b%0d_id", v, b), 64'(q[b].id), 64'(c));
                check($sformatf("vec%0d_b%0d_data", v, b), q[b].d, exp_data(c, exp_cnt[c]));
                check($sformatf("vec%0d_b%0d_user_last", v, b), 64'({q[b].u, q[b].l}),
                      64'({(b % 8) == 0, (b % 8) == 7}));
                if (vecs[v].mode == 0 && b > 0) begin
                    check($sformatf("vec%0d_b%0d_gap", v, b), 64'(q[b].cyc - q[b-1].cyc),
                          64'(((b % 8) == 0) ? 2 : 1));
                end
                exp_cnt[c]++;
            end
        end

        // Reset in the middle of a comp1 block, then comp0 must win first.
        do_reset();
        mask = 3'b010;
        wait_beats(4, "midrst");
        if (q.size() >= 4) check("midrst_pre_id", 64'(q[3].id), 64'(1));
        check("midrst_pre_valid", 64'(out_if.tvalid), 64'(1));
        rst = 1'b1;
        #1;
        check("midrst_async_valid", 64'(out_if.tvalid), 64'(0));
        check("midrst_async_id", 64'(comp_id), 64'(0));
        repeat (2) @(negedge clk);
        clear_sources();
        rst  = 1'b0;
        mask = 3'b011;
        wait_beats(8, "postrst");
        for (int b = 0; b < 8 && b < q.size(); b++) begin
            check($sformatf("postrst_b%0d_id", b), 64'(q[b].id), 64'(0));
            check($sformatf("postrst_b%0d_data", b), q[b].d, exp_data(0, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
